// File: rtl/squarewave_pkg.sv
// rtl/squarewave_pkg.sv - shared types and helpers for the square-wave tone sequencer
package squarewave_pkg;

  localparam int ENTRY_DIV_W = 20;
  localparam int ENTRY_DUR_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [ENTRY_DIV_W-1:0] div;
    logic [ENTRY_DUR_W-1:0] dur;
  } entry_t;

  function automatic int tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/squarewave_sequencer_if.sv
// rtl/squarewave_sequencer_if.sv - table config bus and generator drive bundle
interface squarewave_sequencer_if #(
  parameter int AW    = 3,
  parameter int DIV_W = 20,
  parameter int DUR_W = 12
);

  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [DIV_W-1:0] cfg_div;
  logic [DUR_W-1:0] cfg_dur;
  logic             loop_en;
  logic             gen_enable;
  logic [DIV_W-1:0] gen_half_period;
  logic [AW-1:0]    step_idx;
  logic             busy;
  logic             seq_done;

  modport master (
    output cfg_we, cfg_addr, cfg_div, cfg_dur, loop_en,
    input  gen_enable, gen_half_period, step_idx, busy, seq_done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_div, cfg_dur, loop_en,
    output gen_enable, gen_half_period, step_idx, busy, seq_done
  );

endinterface

// File: rtl/squarewave_sequencer_tick_prescaler.sv
// rtl/squarewave_sequencer_tick_prescaler.sv - free-running timebase divider with sync clear
module tick_prescaler #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == TOP) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == TOP);

endmodule

// File: rtl/squarewave_sequencer.sv
// rtl/squarewave_sequencer.sv - steps the square-wave generator through a table of tones
module squarewave_sequencer
  import squarewave_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int STEPS     = 8,
  parameter int DIV_W     = ENTRY_DIV_W,
  parameter int DUR_W     = ENTRY_DUR_W,
  parameter int GAP_TICKS = 1
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 Enable_SW_3,
  squarewave_sequencer_if.slave bus
);

  localparam int TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
  localparam int AW       = $clog2(STEPS);
  localparam logic [AW-1:0]    LAST_IDX = AW'(STEPS - 1);
  localparam logic [DUR_W-1:0] GAP_LEN  = DUR_W'(GAP_TICKS);

  logic sw_meta, sw_s, sw_d;
  logic start, abort;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= 1'b0;
      sw_s    <= 1'b0;
      sw_d    <= 1'b0;
    end else begin
      sw_meta <= Enable_SW_3;
      sw_s    <= sw_meta;
      sw_d    <= sw_s;
    end
  end

  assign start = sw_s & ~sw_d;
  assign abort = ~sw_s;

  entry_t tbl_q [STEPS];
  entry_t cur_entry;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) tbl_q[i] <= '0;
    end else if (bus.cfg_we) begin
      tbl_q[bus.cfg_addr] <= {bus.cfg_div, bus.cfg_dur};
    end
  end

  state_e           state;
  logic             gen_enable_q;
  logic [DIV_W-1:0] gen_half_period_q;
  logic [AW-1:0]    step_idx_q;
  logic             busy_q;
  logic             seq_done_q;
  logic [DUR_W-1:0] cur_dur;
  logic             played;

  // Read happens before any same-edge cfg write lands, so LOAD sees the old entry.
  assign cur_entry = tbl_q[step_idx_q];

  logic             in_phase, phase_end, tick, presc_clr;
  logic [DUR_W-1:0] tick_cnt, phase_len;

  assign in_phase  = (state == ST_PLAY) || (state == ST_GAP);
  assign phase_len = (state == ST_PLAY) ? cur_dur : GAP_LEN;
  assign phase_end = in_phase && tick && (tick_cnt == phase_len - DUR_W'(1));
  assign presc_clr = !in_phase || phase_end;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk  (sysclk),
    .rst_n(rst_n),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (presc_clr) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + DUR_W'(1);
    end
  end

  logic          last, do_adv;
  state_e        adv_state;
  logic [AW-1:0] adv_idx;

  assign last   = (step_idx_q == LAST_IDX);
  assign do_adv = ((state == ST_LOAD) && (cur_entry.dur == '0)) ||
                  ((state == ST_PLAY) && phase_end && (GAP_TICKS == 0)) ||
                  ((state == ST_GAP) && phase_end);

  // Wrapping needs a played step this pass, otherwise an all-skip table would spin forever.
  always_comb begin
    adv_state = ST_LOAD;
    adv_idx   = step_idx_q + AW'(1);
    if (last) begin
      if (bus.loop_en && played) begin
        adv_idx = '0;
      end else begin
        adv_state = ST_DONE;
        adv_idx   = step_idx_q;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      gen_enable_q      <= 1'b0;
      gen_half_period_q <= '0;
      step_idx_q        <= '0;
      busy_q            <= 1'b0;
      seq_done_q        <= 1'b0;
      cur_dur           <= '0;
      played            <= 1'b0;
    end else begin
      seq_done_q <= 1'b0;
      if (state != ST_IDLE && abort) begin
        state        <= ST_IDLE;
        gen_enable_q <= 1'b0;
        busy_q       <= 1'b0;
      end else if (do_adv) begin
        state        <= adv_state;
        step_idx_q   <= adv_idx;
        gen_enable_q <= 1'b0;
        seq_done_q   <= (adv_state == ST_DONE);
        if (last) played <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state      <= ST_LOAD;
              step_idx_q <= '0;
              played     <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
          ST_LOAD: begin
            state             <= ST_PLAY;
            gen_enable_q      <= (cur_entry.div != '0);
            gen_half_period_q <= cur_entry.div;
            cur_dur           <= cur_entry.dur;
            played            <= 1'b1;
          end
          ST_PLAY: begin
            if (phase_end) begin
              state        <= ST_GAP;
              gen_enable_q <= 1'b0;
            end
          end
          ST_GAP: ;
          ST_DONE: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.gen_enable      = gen_enable_q;
  assign bus.gen_half_period = gen_half_period_q;
  assign bus.step_idx        = step_idx_q;
  assign bus.busy            = busy_q;
  assign bus.seq_done        = seq_done_q;

endmodule

// File: tb/tb_squarewave_sequencer.sv
// tb/tb_squarewave_sequencer.sv - scoreboard bench comparing output segments against hand-built expectations
module tb_squarewave_sequencer;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b1;
  logic sw     = 1'b0;

  always #5 sysclk = ~sysclk;

  squarewave_sequencer_if #(.AW(2), .DIV_W(20), .DUR_W(12)) bus ();

  squarewave_sequencer #(
    .CLK_HZ(1000), .TICK_HZ(100), .STEPS(4), .DIV_W(20), .DUR_W(12), .GAP_TICKS(1)
  ) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .Enable_SW_3(sw),
    .bus        (bus)
  );

  typedef struct packed {
    logic        en;
    logic [19:0] hp;
    logic [1:0]  idx;
    logic        busy;
    logic        done;
  } obs_t;

  typedef struct {
    obs_t o;
    int   len;
  } seg_t;

  seg_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   seg_n = 0;
  bit   mon_en = 1'b0;
  bit   mon_started = 1'b0;
  obs_t cur_o;
  int   cur_len;

  function automatic obs_t get_obs();
    return {bus.gen_enable, bus.gen_half_period, bus.step_idx, bus.busy, bus.seq_done};
  endfunction

  task automatic push(input bit en, input int hp, input int idx, input bit busy, input bit done,
                      input int len);
    seg_t e;
    e.o   = {en, 20'(hp), 2'(idx), busy, done};
    e.len = len;
    exp_q.push_back(e);
  endtask

  // One table pass; len 0 segments accept any length (idle stretches).
  task automatic push_pass(input int prev_hp, input int div0, input int len0);
    push(0, prev_hp, 0, 1, 0, 1);
    push(1, div0, 0, 1, 0, len0);
    push(0, div0, 0, 1, 0, 10);
    push(0, div0, 1, 1, 0, 1);
    push(0, 0, 1, 1, 0, 20);
    push(0, 0, 2, 1, 0, 1);
    push(1, 50, 2, 1, 0, 30);
    push(0, 50, 2, 1, 0, 10);
    push(0, 50, 3, 1, 0, 1);
    push(1, 200, 3, 1, 0, 10);
    push(0, 200, 3, 1, 0, 10);
  endtask

  task automatic close_seg();
    seg_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL seg_extra: got en=%b hp=%0d idx=%0d busy=%b done=%b len=%0d, required no segment",
               cur_o.en, cur_o.hp, cur_o.idx, cur_o.busy, cur_o.done, cur_len);
    end else begin
      e = exp_q.pop_front();
      if (cur_o !== e.o || (e.len != 0 && cur_len != e.len)) begin
        fails++;
        $display("FAIL seg%0d: got en=%b hp=%0d idx=%0d busy=%b done=%b len=%0d, required en=%b hp=%0d idx=%0d busy=%b done=%b len=%0d",
                 seg_n, cur_o.en, cur_o.hp, cur_o.idx, cur_o.busy, cur_o.done, cur_len,
                 e.o.en, e.o.hp, e.o.idx, e.o.busy, e.o.done, e.len);
      end
    end
    seg_n++;
  endtask

  initial begin
    obs_t s;
    forever begin
      @(negedge sysclk);
      if (mon_en) begin
        s = get_obs();
        if (!mon_started) begin
          cur_o = s;
          cur_len = 1;
          mon_started = 1'b1;
        end else if (s !== cur_o) begin
          close_seg();
          cur_o = s;
          cur_len = 1;
        end else begin
          cur_len++;
        end
      end
    end
  end

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic bit cond(input int kind);
    case (kind)
      0:       return bus.gen_enable && bus.step_idx == 2'd2;
      1:       return bus.gen_enable && bus.step_idx == 2'd0;
      2:       return !bus.gen_enable && bus.gen_half_period == 20'd77 && bus.busy && bus.step_idx == 2'd0;
      3:       return bus.step_idx == 2'd1 && bus.gen_half_period == 20'd0 && bus.busy;
      default: return !bus.busy;
    endcase
  endfunction

  task automatic wait_rise(input int kind, input int nth, input string name);
    int hits = 0;
    int n = 0;
    bit prev, now;
    prev = cond(kind);
    while (hits < nth && n < 3000) begin
      @(negedge sysclk);
      n++;
      now = cond(kind);
      if (now && !prev) hits++;
      prev = now;
    end
    check(name, hits >= nth, hits, nth);
  endtask

  task automatic cfg_write(input int a, input int d, input int u);
    @(negedge sysclk);
    #1;
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 2'(a);
    bus.cfg_div  = 20'(d);
    bus.cfg_dur  = 12'(u);
    @(negedge sysclk);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_div  = '0;
    bus.cfg_dur  = '0;
    bus.loop_en  = 1'b0;
    #1 rst_n = 1'b0;
    push(0, 0, 0, 0, 0, 0);
    @(negedge sysclk);
    #1 mon_en = 1'b1;
    repeat (3) @(negedge sysclk);
    #1 rst_n = 1'b1;
    cfg_write(0, 100, 2);
    cfg_write(1, 0, 1);
    cfg_write(2, 50, 3);
    cfg_write(3, 200, 1);

    // single pass, switch held high afterwards must not retrigger
    push_pass(0, 100, 20);
    push(0, 200, 3, 1, 1, 1);
    push(0, 200, 3, 0, 0, 0);
    @(negedge sysclk);
    #1 sw = 1'b1;
    wait_rise(4, 1, "t1_done_wait");
    repeat (30) @(negedge sysclk);
    #1 sw = 1'b0;
    repeat (5) @(negedge sysclk);

    // looping: three identical passes, then abort mid-PLAY of step 2
    for (int p = 0; p < 3; p++) push_pass(200, 100, 20);
    push(0, 200, 0, 1, 0, 1);
    push(1, 100, 0, 1, 0, 20);
    push(0, 100, 0, 1, 0, 10);
    push(0, 100, 1, 1, 0, 1);
    push(0, 0, 1, 1, 0, 20);
    push(0, 0, 2, 1, 0, 1);
    push(1, 50, 2, 1, 0, 13);
    push(0, 50, 2, 0, 0, 0);
    #1 bus.loop_en = 1'b1;
    sw = 1'b1;
    wait_rise(0, 4, "t2_pass4_wait");
    repeat (10) @(negedge sysclk);
    #1 sw = 1'b0;
    repeat (10) @(negedge sysclk);

    // rewrite entry 0 while it plays; change shows on the next pass
    push_pass(50, 100, 20);
    push(0, 200, 0, 1, 0, 1);
    push(1, 77, 0, 1, 0, 10);
    push(0, 77, 0, 1, 0, 3);
    push(0, 77, 0, 0, 0, 0);
    #1 sw = 1'b1;
    wait_rise(1, 1, "t6_play0_wait");
    #1;
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 2'd0;
    bus.cfg_div  = 20'd77;
    bus.cfg_dur  = 12'd1;
    @(negedge sysclk);
    #1 bus.cfg_we = 1'b0;
    wait_rise(2, 1, "t6_gap77_wait");
    #1 sw = 1'b0;
    repeat (10) @(negedge sysclk);

    // async reset during GAP of step 1
    bus.loop_en = 1'b0;
    push(0, 77, 0, 1, 0, 1);
    push(1, 77, 0, 1, 0, 10);
    push(0, 77, 0, 1, 0, 10);
    push(0, 77, 1, 1, 0, 1);
    push(0, 0, 1, 1, 0, 16);
    push(0, 0, 0, 0, 0, 0);
    @(negedge sysclk);
    #1 sw = 1'b1;
    wait_rise(3, 1, "t5_step1_wait");
    repeat (15) @(negedge sysclk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_gen_enable", bus.gen_enable === 1'b0, bus.gen_enable, 0);
    check("rst_half_period", bus.gen_half_period === 20'd0, bus.gen_half_period, 0);
    check("rst_step_idx", bus.step_idx === 2'd0, bus.step_idx, 0);
    check("rst_busy", bus.busy === 1'b0, bus.busy, 0);
    check("rst_seq_done", bus.seq_done === 1'b0, bus.seq_done, 0);
    sw = 1'b0;
    repeat (3) @(negedge sysclk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge sysclk);

    // cleared table: every step skipped, no wrap despite loop_en
    push(0, 0, 0, 1, 0, 1);
    push(0, 0, 1, 1, 0, 1);
    push(0, 0, 2, 1, 0, 1);
    push(0, 0, 3, 1, 0, 1);
    push(0, 0, 3, 1, 1, 1);
    push(0, 0, 3, 0, 0, 0);
    #1 bus.loop_en = 1'b1;
    sw = 1'b1;
    wait_rise(4, 1, "t4_done_wait");
    repeat (10) @(negedge sysclk);
    #1 sw = 1'b0;
    repeat (5) @(negedge sysclk);

    #1 mon_en = 1'b0;
    close_seg();
    check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
